// File: rtl/axis_pingpong_frame_buffer_if.sv
// axis_pingpong_frame_buffer_if
// AXI-Stream bundle used on both sides of axis_pingpong_frame_buffer.
//   tdata  : payload word
//   tvalid : word valid (source to sink)
//   tready : sink accepts the word (sink to source)
//   tlast  : last word of a frame
// modport master : the side that sources the stream
// modport slave  : the side that sinks the stream. It carries tlast only when
//                  AXIS_FB_TLAST_IN_EN is defined, because without that option
//                  the buffer has no input tlast.
interface axis_pingpong_frame_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
`ifdef AXIS_FB_TLAST_IN_EN
   modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
   modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/axis_pingpong_frame_buffer.sv
// axis_pingpong_frame_buffer
// Two-bank (ping-pong) AXI-Stream store-and-forward frame buffer.
// One bank collects a complete frame while the other drains it with tlast, so
// the buffer sustains one word per clock.
// Optional feature: define AXIS_FB_TLAST_IN_EN to let an input beat with
// s_axis.tlast=1 close a frame early. Without it every frame is FRAME_LEN words.
// Ports:
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   s_axis      : input stream (slave modport)
//   m_axis      : output stream (master modport); tlast marks the last word
//   o_bank_full : bit b high while bank b holds a complete, undrained frame
//   o_frame_cnt : frames fully drained, wrapping
module axis_pingpong_frame_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAME_LEN  = 24,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   axis_pingpong_frame_buffer_if.slave  s_axis,
   axis_pingpong_frame_buffer_if.master m_axis,
   output logic [1:0]                   o_bank_full,
   output logic [CNT_WIDTH-1:0]         o_frame_cnt
);
   localparam int               PTR_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   logic [DATA_WIDTH-1:0] mem_r [2][FRAME_LEN];
   bank_state_t           bank_state_r [2];
   bank_state_t           bank_state_s [2];
   logic [PTR_W-1:0]      last_idx_r   [2];
   logic                  wr_bank_r, wr_bank_s, rd_bank_r, rd_bank_s;
   logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
   logic                  s_tready_r, s_tready_s;
   logic [DATA_WIDTH-1:0] m_tdata_r;
   logic                  m_tvalid_r, m_tvalid_s, m_tlast_r, m_tlast_s;
   logic                  out_bank_r, out_bank_s;
   logic [1:0]            bank_full_r, bank_full_s;
   logic [CNT_WIDTH-1:0]  frame_cnt_r;
   logic                  in_tlast_s, wr_fire_s, wr_close_s;
   logic                  out_free_s, rd_load_s, rd_last_s, tlast_acc_s;

`ifdef AXIS_FB_TLAST_IN_EN
   assign in_tlast_s = s_axis.tlast;
`else
   assign in_tlast_s = 1'b0;
`endif

   assign wr_fire_s   = s_axis.tvalid & s_tready_r;
   assign wr_close_s  = wr_fire_s & ((wr_ptr_r == LAST_IDX) | in_tlast_s);
   assign out_free_s  = ~m_tvalid_r | m_axis.tready;
   assign tlast_acc_s = m_tvalid_r & m_axis.tready & m_tlast_r;
   assign rd_load_s   = out_free_s & (bank_state_r[rd_bank_r] == BANK_FULL);
   assign rd_last_s   = (rd_ptr_r == last_idx_r[rd_bank_r]);

   // Next-state logic for both bank FSMs, the pointers and the output stage.
   // The write bank is never FULL while tready is high and the read side only
   // touches a FULL bank, so both sides may update different banks on one edge.
   // A bank's memory is released as soon as its last word has moved into the
   // output register; o_bank_full keeps reporting the frame until that tlast
   // beat is accepted. This lets the refill start on the same edge the tlast is
   // accepted, which keeps the input at one word per clock.
   always_comb begin
      bank_state_s = bank_state_r;
      wr_bank_s    = wr_bank_r;
      wr_ptr_s     = wr_ptr_r;
      rd_bank_s    = rd_bank_r;
      rd_ptr_s     = rd_ptr_r;
      m_tvalid_s   = m_tvalid_r;
      m_tlast_s    = m_tlast_r;
      out_bank_s   = out_bank_r;
      if (wr_close_s) begin
         bank_state_s[wr_bank_r] = BANK_FULL;
         wr_ptr_s                = '0;
         wr_bank_s               = ~wr_bank_r;
      end else if (wr_fire_s) begin
         bank_state_s[wr_bank_r] = BANK_FILLING;
         wr_ptr_s                = wr_ptr_r + PTR_W'(1);
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      if (rd_load_s) begin
         m_tvalid_s = 1'b1;
         m_tlast_s  = rd_last_s;
         out_bank_s = rd_bank_r;
         if (rd_last_s) begin
            bank_state_s[rd_bank_r] = BANK_EMPTY;
            rd_ptr_s                = '0;
            rd_bank_s               = ~rd_bank_r;
         end else begin
            rd_ptr_s = rd_ptr_r + PTR_W'(1);
         end
      end else if (m_tvalid_r & m_axis.tready) begin
         m_tvalid_s = 1'b0;
         m_tlast_s  = 1'b0;
      end else begin
         m_tvalid_s = m_tvalid_r;
      end
      s_tready_s = (bank_state_s[wr_bank_s] != BANK_FULL);
      for (int b = 0; b < 2; b++) begin
         bank_full_s[b] = (bank_state_s[b] == BANK_FULL) |
                          (m_tvalid_s & m_tlast_s & (out_bank_s == 1'(b)));
      end
   end

   // State, pointer, output and counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bank_state_r[0] <= BANK_EMPTY;
         bank_state_r[1] <= BANK_EMPTY;
         last_idx_r[0]   <= LAST_IDX;
         last_idx_r[1]   <= LAST_IDX;
         wr_bank_r       <= 1'b0;
         rd_bank_r       <= 1'b0;
         wr_ptr_r        <= '0;
         rd_ptr_r        <= '0;
         s_tready_r      <= 1'b1;
         m_tdata_r       <= '0;
         m_tvalid_r      <= 1'b0;
         m_tlast_r       <= 1'b0;
         out_bank_r      <= 1'b0;
         bank_full_r     <= 2'b00;
         frame_cnt_r     <= '0;
      end else begin
         bank_state_r <= bank_state_s;
         wr_bank_r    <= wr_bank_s;
         rd_bank_r    <= rd_bank_s;
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         s_tready_r   <= s_tready_s;
         m_tvalid_r   <= m_tvalid_s;
         m_tlast_r    <= m_tlast_s;
         out_bank_r   <= out_bank_s;
         bank_full_r  <= bank_full_s;
         if (wr_close_s) begin
            last_idx_r[wr_bank_r] <= wr_ptr_r;
         end
         if (rd_load_s) begin
            m_tdata_r <= mem_r[rd_bank_r][rd_ptr_r];
         end
         if (tlast_acc_s) begin
            frame_cnt_r <= frame_cnt_r + CNT_WIDTH'(1);
         end
      end
   end

   // Bank storage; deliberately not cleared by reset.
   always_ff @(posedge i_clk) begin
      if (wr_fire_s) begin
         mem_r[wr_bank_r][wr_ptr_r] <= s_axis.tdata;
      end
   end

   assign s_axis.tready = s_tready_r;
   assign m_axis.tdata  = m_tdata_r;
   assign m_axis.tvalid = m_tvalid_r;
   assign m_axis.tlast  = m_tlast_r;
   assign o_bank_full   = bank_full_r;
   assign o_frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_axis_pingpong_frame_buffer.sv
module tb_axis_pingpong_frame_buffer;
   localparam int DW = 32;
   localparam int FL = 24;
   localparam int CW = 16;
`ifdef AXIS_FB_TLAST_IN_EN
   localparam bit TL_EN = 1'b1;
`else
   localparam bit TL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    bank_full;
   logic [CW-1:0] frame_cnt;

   axis_pingpong_frame_buffer_if #(.DATA_WIDTH(DW)) s_if();
   axis_pingpong_frame_buffer_if #(.DATA_WIDTH(DW)) m_if();

   axis_pingpong_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .s_axis      (s_if),
      .m_axis      (m_if),
      .o_bank_full (bank_full),
      .o_frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          ready_mode = 0;   // 0: never ready, 1: always ready, 2: random
   int          neg_cyc = 0;
   // reference model: words of the frame being collected, then frames queued for output
   logic [DW-1:0] cur_q[$];
   logic [DW-1:0] exp_d[$];
   bit            exp_l[$];
   int            out_lens[$];
   int            cur_out_len;
   logic [CW-1:0] model_cnt;
   int            close_neg, first_valid_neg, first_out_neg, last_out_neg, stall_cnt;
   logic [DW-1:0] last_out_data;
   bit            stall_prev;
   logic [DW-1:0] prev_d;
   logic          prev_l;

   task automatic clear_model();
      cur_q.delete(); exp_d.delete(); exp_l.delete(); out_lens.delete();
      cur_out_len = 0; model_cnt = '0; stall_prev = 1'b0; stall_cnt = 0;
      close_neg = -1; first_valid_neg = -1; first_out_neg = -1; last_out_neg = -1;
      last_out_data = '0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // downstream ready generator
   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_if.tready = 1'b0;
            1:       m_if.tready = 1'b1;
            default: m_if.tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // compare process: handshakes are decided at the next rising edge,
   // so everything is observed on the falling edge
   initial begin
      logic [DW-1:0] ed;
      bit            el;
      forever begin
         @(negedge clk);
         neg_cyc++;
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            checks++;
            if (frame_cnt !== model_cnt) begin
               errors++;
               $display("FAIL frame_cnt: got %0d, expected %0d", frame_cnt, model_cnt);
            end
            if (s_if.tvalid && s_if.tready) begin
               cur_q.push_back(s_if.tdata);
               if (cur_q.size() == FL || (TL_EN && s_if.tlast)) begin
                  for (int k = 0; k < cur_q.size(); k++) begin
                     exp_d.push_back(cur_q[k]);
                     exp_l.push_back(k == cur_q.size() - 1);
                  end
                  cur_q.delete();
                  close_neg = neg_cyc;
               end
            end
            if (stall_prev) begin
               checks++;
               if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_d || m_if.tlast !== prev_l) begin
                  errors++;
                  $display("FAIL hold_stable: tvalid=%0b tdata=%0h tlast=%0b, held tdata=%0h tlast=%0b",
                           m_if.tvalid, m_if.tdata, m_if.tlast, prev_d, prev_l);
               end
            end
            if (first_valid_neg < 0 && m_if.tvalid === 1'b1) first_valid_neg = neg_cyc;
            if (m_if.tvalid && m_if.tready) begin
               checks++;
               if (exp_d.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out: tdata=%0h tlast=%0b, expected no output", m_if.tdata, m_if.tlast);
               end else begin
                  ed = exp_d.pop_front();
                  el = exp_l.pop_front();
                  if (m_if.tdata !== ed || m_if.tlast !== el) begin
                     errors++;
                     $display("FAIL scoreboard: tdata=%0h tlast=%0b, expected tdata=%0h tlast=%0b",
                              m_if.tdata, m_if.tlast, ed, el);
                  end
                  if (el) model_cnt = model_cnt + 1'b1;
               end
               cur_out_len++;
               if (m_if.tlast) begin
                  out_lens.push_back(cur_out_len);
                  cur_out_len = 0;
               end
               if (first_out_neg < 0) first_out_neg = neg_cyc;
               last_out_neg  = neg_cyc;
               last_out_data = m_if.tdata;
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_d     = m_if.tdata;
            prev_l     = m_if.tlast;
         end
      end
   end

   task automatic reset_dut();
      rst = 1'b1; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
   endtask

   // sends n beats; seq selects base+i data, otherwise random; gap_pct inserts idle cycles
   task automatic send_words(input int n, input bit seq, input logic [DW-1:0] base,
                             input int gap_pct, input int tlast_idx);
      for (int i = 0; i < n; i++) begin
         logic acc;
         int   guard;
         while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            s_if.tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_if.tdata  = seq ? base + DW'(i) : DW'($urandom);
         s_if.tvalid = 1'b1;
         s_if.tlast  = (i == tlast_idx);
         acc = 1'b0; guard = 0;
         while (!acc && guard < 2000) begin
            @(negedge clk); acc = s_if.tready;
            @(posedge clk); #1;
            if (!acc) begin stall_cnt++; guard++; end
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %0d not accepted, expected acceptance", i);
         end
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_d.size() != 0 || m_if.tvalid === 1'b1) && n < 5000) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      chk({tag, "_drained"}, 64'(n < 5000), 64'd1);
      chk({tag, "_partial_left"}, 64'(cur_q.size()), 64'd0);
   endtask

   initial begin
      bit found;
      int n;
      clear_model();
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;

      // reset state
      reset_dut();
      @(negedge clk);
      chk("rst_s_tready", 64'(s_if.tready), 64'd1);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
      chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
      chk("rst_bank_full", 64'(bank_full),  64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt),  64'd0);

      // one frame 0..23, downstream always ready
      ready_mode = 1;
      @(posedge clk); #1;
      send_words(FL, 1'b1, '0, 0, -1);
      wait_drain("t1");
      chk("t1_latency_clk", 64'(first_valid_neg - close_neg - 1), 64'd1);
      chk("t1_frames", 64'(out_lens.size()), 64'd1);
      if (out_lens.size() > 0) chk("t1_frame_len", 64'(out_lens[0]), 64'd24);
      chk("t1_last_word", 64'(last_out_data), 64'd23);
      chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
      chk("t1_bank_full", 64'(bank_full), 64'd0);

      // 96 words back to back
      reset_dut();
      ready_mode = 1;
      @(posedge clk); #1;
      send_words(4 * FL, 1'b0, '0, 0, -1);
      chk("t2_in_stalls", 64'(stall_cnt), 64'd0);
      wait_drain("t2");
      chk("t2_out_span", 64'(last_out_neg - first_out_neg), 64'd95);
      chk("t2_frames", 64'(out_lens.size()), 64'd4);
      chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);

      // both banks filled with downstream blocked
      reset_dut();
      ready_mode = 0;
      @(posedge clk); #1;
      send_words(2 * FL, 1'b0, '0, 0, -1);
      @(negedge clk);
      chk("t3_bank_full", 64'(bank_full), 64'd3);
      chk("t3_s_tready_low", 64'(s_if.tready), 64'd0);
      ready_mode = 1;
      found = 1'b0; n = 0;
      while (!found && n < 500) begin
         @(negedge clk); n++;
         if (m_if.tvalid && m_if.tready && m_if.tlast) found = 1'b1;
      end
      chk("t3_first_tlast", 64'(found), 64'd1);
      @(negedge clk);
      chk("t3_s_tready_back", 64'(s_if.tready), 64'd1);
      wait_drain("t3");
      chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);
      chk("t3_bank_full_end", 64'(bank_full), 64'd0);

      // random downstream ready, random input gaps, 10 frames
      reset_dut();
      ready_mode = 2;
      @(posedge clk); #1;
      send_words(10 * FL, 1'b0, '0, 20, -1);
      wait_drain("t4");
      chk("t4_frames", 64'(out_lens.size()), 64'd10);
      for (int f = 0; f < out_lens.size(); f++) chk("t4_frame_len", 64'(out_lens[f]), 64'd24);
      chk("t4_frame_cnt", 64'(frame_cnt), 64'd10);

      // reset during word 10 of frame 2
      reset_dut();
      ready_mode = 1;
      @(posedge clk); #1;
      send_words(2 * FL + 10, 1'b1, 32'h0000_5000, 0, -1);
      s_if.tdata = 32'hDEAD_BEEF; s_if.tvalid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; s_if.tvalid = 1'b0;
      clear_model();
      @(negedge clk);
      chk("t5_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("t5_s_tready", 64'(s_if.tready), 64'd1);
      chk("t5_frame_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk); #1;
      send_words(FL, 1'b1, 32'h0000_A000, 0, -1);
      wait_drain("t5");
      chk("t5_frames", 64'(out_lens.size()), 64'd1);
      if (out_lens.size() > 0) chk("t5_frame_len", 64'(out_lens[0]), 64'd24);
      chk("t5_last_word", 64'(last_out_data), 64'h0000_A017);
      chk("t5_frame_cnt_end", 64'(frame_cnt), 64'd1);

`ifdef AXIS_FB_TLAST_IN_EN
      // early close by input tlast, then a full frame
      reset_dut();
      ready_mode = 1;
      @(posedge clk); #1;
      send_words(5, 1'b1, 32'h0000_0100, 0, 4);
      send_words(FL, 1'b1, 32'h0000_0200, 0, -1);
      wait_drain("t6");
      chk("t6_frames", 64'(out_lens.size()), 64'd2);
      if (out_lens.size() > 1) begin
         chk("t6_len0", 64'(out_lens[0]), 64'd5);
         chk("t6_len1", 64'(out_lens[1]), 64'd24);
      end
      chk("t6_frame_cnt", 64'(frame_cnt), 64'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
